// File: rtl/sub8_serial_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// SUB8_SERIAL_OVF_EN adds the signed-overflow flag.
interface sub8_serial_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bi;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] d;
   logic             bo;
`ifdef SUB8_SERIAL_OVF_EN
   logic             ovf;
`endif

   modport master (
      output start, a, b, bi,
      input  busy, done, d, bo
`ifdef SUB8_SERIAL_OVF_EN
      , input ovf
`endif
   );

   modport slave (
      input  start, a, b, bi,
      output busy, done, d, bo
`ifdef SUB8_SERIAL_OVF_EN
      , output ovf
`endif
   );
endinterface

// File: rtl/sub8_serial.sv
// Bit-serial subtractor d = a - b - bi, LSB first, one borrow flop, start/busy/done.
// Optional SUB8_SERIAL_OVF_EN builds the signed-overflow output.
module sub8_serial #(
   parameter int unsigned WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   sub8_serial_if.slave   bus
);
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res;
   logic [CW-1:0]    cnt;
   logic             br;
   logic             busy_q;
   logic             done_q;
   logic             bo_q;
`ifdef SUB8_SERIAL_OVF_EN
   logic             ovf_q;
`endif

   // One full-subtractor slice on the current LSBs
   logic bit_d_c;
   logic br_nxt_c;
   assign bit_d_c  = a_sh[0] ^ b_sh[0] ^ br;
   assign br_nxt_c = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         res    <= '0;
         cnt    <= '0;
         br     <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         bo_q   <= 1'b0;
`ifdef SUB8_SERIAL_OVF_EN
         ovf_q  <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  a_sh   <= bus.a;
                  b_sh   <= bus.b;
                  br     <= bus.bi;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end else begin
                  state  <= IDLE;
               end
            end
            RUN: begin
               // Result fills from the MSB end so it is aligned after WIDTH shifts
               res  <= {bit_d_c, res[WIDTH-1:1]};
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               br   <= br_nxt_c;
               cnt  <= cnt + CW'(1);
               if (cnt == LAST) begin
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  bo_q   <= br_nxt_c;
`ifdef SUB8_SERIAL_OVF_EN
                  // On the last bit a_sh[0]/b_sh[0] are the operand sign bits
                  ovf_q  <= (a_sh[0] ^ b_sh[0]) & (bit_d_c ^ a_sh[0]);
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.d    = res;
   assign bus.bo   = bo_q;
`ifdef SUB8_SERIAL_OVF_EN
   assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_sub8_serial.sv
// Scoreboard bench for sub8_serial: directed cases plus random start/operand traffic.
module tb_sub8_serial;
   localparam int W = 8;

   typedef struct {
      logic [W-1:0] d;
      logic         bo;
      logic         ovf;
      int           due;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   last_acc = -1000;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   sub8_serial_if #(.WIDTH(W)) bus ();

   sub8_serial #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain integer arithmetic on the operands
   function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic biv, input int due);
      exp_t e;
      int   full;
      logic [31:0] fv;
      full  = int'(av) - int'(bv) - int'(biv);
      fv    = full;
      e.d   = fv[W-1:0];
      e.bo  = (full < 0);
      e.ovf = (av[W-1] != bv[W-1]) && (e.d[W-1] != av[W-1]);
      e.due = due;
      return e;
   endfunction

   // One clock of stimulus; the model decides acceptance and checks busy/done
   task automatic step(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic biv);
      int e;
      @(negedge clk);
      bus.start = s;
      bus.a     = av;
      bus.b     = bv;
      bus.bi    = biv;
      @(posedge clk);
      #1;
      e = cyc;
      if (s && rst_n && (e > last_acc + W)) begin
         sb.push_back(model(av, bv, biv, e + W));
         last_acc = e;
      end
      chk("busy", 32'(bus.busy), 32'(rst_n && (e >= last_acc) && (e < last_acc + W)));
      chk("done", 32'(bus.done), 32'(rst_n && (e == last_acc + W)));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, W'($urandom), W'($urandom), 1'($urandom));
   endtask

   // Monitor: pops the scoreboard whenever the DUT reports a result
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("d", 32'(bus.d), 32'(e.d));
               chk("bo", 32'(bus.bo), 32'(e.bo));
               chk("latency", 32'(cyc), 32'(e.due));
`ifdef SUB8_SERIAL_OVF_EN
               chk("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
            end
         end
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
      chk({tag, "_d"}, 32'(bus.d), 32'd0);
      chk({tag, "_bo"}, 32'(bus.bo), 32'd0);
`ifdef SUB8_SERIAL_OVF_EN
      chk({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
`endif
   endtask

   initial begin
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.bi    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Basic, wrap-around and signed-overflow cases
      step(1'b1, 8'h05, 8'h03, 1'b0);
      idle(10);
      step(1'b1, 8'h00, 8'h01, 1'b0);
      idle(10);
      step(1'b1, 8'h80, 8'h00, 1'b1);
      idle(10);

      // Start during RUN is ignored
      step(1'b1, 8'h5A, 8'h21, 1'b0);
      idle(2);
      step(1'b1, 8'h11, 8'h99, 1'b1);
      idle(8);

      // Reset in the 4th RUN cycle aborts with no result
      step(1'b1, 8'h33, 8'h44, 1'b1);
      idle(3);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("abort");
      sb.delete();
      last_acc = -1000;
      idle(2);
      @(negedge clk);
      rst_n = 1'b1;
      idle(10);

      // Start held high through DONE gives back-to-back operations
      step(1'b1, 8'hFF, 8'hFF, 1'b0);
      for (int i = 0; i < 9; i++) step(1'b1, 8'h10, 8'h20, 1'b0);
      idle(12);

      // Random traffic, including starts while busy and held starts
      for (int i = 0; i < 600; i++)
         step(1'($urandom_range(0, 2) == 0), W'($urandom), W'($urandom), 1'($urandom));
      idle(12);

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
